// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder stage, the summing accumulator and its consumer.
// The slave modport is the accumulator; the master modport is the surrounding logic.
interface sum_accumulator_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 7
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sum_in;
    logic              cout_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;
    logic              busy;

    modport slave (
        input  start, in_valid, sum_in, cout_in, out_ready,
        output in_ready, out_valid, acc_out, ovf, busy
    );

    modport master (
        output start, in_valid, sum_in, cout_in, out_ready,
        input  in_ready, out_valid, acc_out, ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Sums NUM_TERMS {cout, sum} adder results into an ACC_W accumulator with a sticky overflow flag.
// Optional macro SUM_ACC_SATURATE_EN clamps the total at all-ones instead of wrapping.
module sum_accumulator #(
    parameter int DATA_W    = 4,
    parameter int ACC_W     = 7,
    parameter int NUM_TERMS = 4
) (
    input  logic clk,
    input  logic rst_n,
    sum_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic             w_clear;
    logic             w_accept;
    logic [ACC_W:0]   w_term;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_new;

    // One extra bit on the adder exposes the carry out of the accumulator MSB.
    assign w_term = (ACC_W + 1)'({bus.cout_in, bus.sum_in});
    assign w_sum  = {1'b0, r_acc} + w_term;

`ifdef SUM_ACC_SATURATE_EN
    assign w_acc_new = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_new = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start arriving alongside out_ready is dropped on purpose.
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_clear) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_acc_new;
            r_ovf   <= r_ovf | w_sum[ACC_W];
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
    assign bus.acc_out   = r_acc;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build, a 6-bit accumulator copy and a single-term copy.
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.DATA_W(4), .ACC_W(7)) ifm ();
    sum_accumulator_if #(.DATA_W(4), .ACC_W(6)) if6 ();
    sum_accumulator_if #(.DATA_W(4), .ACC_W(7)) if1 ();

    // The narrow copy mirrors the main stimulus so its overflow behaviour can be compared side by side.
    assign if6.start     = ifm.start;
    assign if6.in_valid  = ifm.in_valid;
    assign if6.sum_in    = ifm.sum_in;
    assign if6.cout_in   = ifm.cout_in;
    assign if6.out_ready = ifm.out_ready;

    sum_accumulator #(.DATA_W(4), .ACC_W(7), .NUM_TERMS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifm)
    );

    sum_accumulator #(.DATA_W(4), .ACC_W(6), .NUM_TERMS(4)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if6)
    );

    sum_accumulator #(.DATA_W(4), .ACC_W(7), .NUM_TERMS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_term(input int v);
        ifm.in_valid = 1'b1;
        ifm.cout_in  = v[4];
        ifm.sum_in   = v[3:0];
    endtask

    task automatic pulse_start();
        ifm.start = 1'b1;
        tick();
        ifm.start = 1'b0;
    endtask

    task automatic test_reset();
        ifm.start = 1'b0; ifm.in_valid = 1'b0; ifm.sum_in = '0; ifm.cout_in = 1'b0; ifm.out_ready = 1'b0;
        if1.start = 1'b0; if1.in_valid = 1'b0; if1.sum_in = '0; if1.cout_in = 1'b0; if1.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ifm.acc_out !== 7'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", ifm.acc_out); end
        checks++; if (ifm.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ifm.ovf); end
        checks++; if ({ifm.in_ready, ifm.out_valid, ifm.busy} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {ifm.in_ready, ifm.out_valid, ifm.busy});
        end
        rst_n = 1'b1;
        tick();
        checks++; if (ifm.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", ifm.busy); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        pulse_start();
        checks++; if ({ifm.in_ready, ifm.busy} !== 2'b11) begin
            failures++; $display("FAIL accum_flags got=%b exp=11", {ifm.in_ready, ifm.busy});
        end
        for (int i = 1; i <= 4; i++) begin
            drive_term(i);
            tick();
            if (i == 3) begin
                checks++; if (ifm.out_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%0b exp=0", ifm.out_valid); end
                checks++; if (ifm.acc_out !== 7'd6) begin failures++; $display("FAIL partial_acc got=%0d exp=6", ifm.acc_out); end
            end
        end
        ifm.in_valid = 1'b0;
        checks++; if (ifm.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", ifm.out_valid); end
        checks++; if (ifm.acc_out !== 7'd10) begin failures++; $display("FAIL basic_acc got=%0d exp=10", ifm.acc_out); end
        checks++; if (ifm.ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", ifm.ovf); end
        checks++; if ({ifm.in_ready, ifm.busy} !== 2'b01) begin
            failures++; $display("FAIL done_flags got=%b exp=01", {ifm.in_ready, ifm.busy});
        end
        ifm.out_ready = 1'b1;
        tick();
        ifm.out_ready = 1'b0;
        checks++; if ({ifm.out_valid, ifm.busy} !== 2'b00) begin
            failures++; $display("FAIL basic_idle got=%b exp=00", {ifm.out_valid, ifm.busy});
        end
        checks++; if (ifm.acc_out !== 7'd10) begin failures++; $display("FAIL basic_retain got=%0d exp=10", ifm.acc_out); end
        $display("test_basic done acc=%0d", ifm.acc_out);
    endtask

    task automatic test_overflow();
        logic [5:0] exp6;
`ifdef SUM_ACC_SATURATE_EN
        exp6 = 6'd63;
`else
        exp6 = 6'd60;
`endif
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_term(31);
            tick();
        end
        ifm.in_valid = 1'b0;
        checks++; if (ifm.acc_out !== 7'd124) begin failures++; $display("FAIL big_acc got=%0d exp=124", ifm.acc_out); end
        checks++; if (ifm.ovf !== 1'b0) begin failures++; $display("FAIL big_ovf got=%0b exp=0", ifm.ovf); end
        checks++; if (if6.acc_out !== exp6) begin failures++; $display("FAIL narrow_acc got=%0d exp=%0d", if6.acc_out, exp6); end
        checks++; if (if6.ovf !== 1'b1) begin failures++; $display("FAIL narrow_ovf got=%0b exp=1", if6.ovf); end
        ifm.out_ready = 1'b1;
        tick();
        ifm.out_ready = 1'b0;
        checks++; if (if6.ovf !== 1'b1) begin failures++; $display("FAIL narrow_ovf_retain got=%0b exp=1", if6.ovf); end
        $display("test_overflow done acc=%0d acc6=%0d", ifm.acc_out, if6.acc_out);
    endtask

    task automatic test_gaps();
        int terms[4] = '{6, 7, 8, 9};
        int partial = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_term(terms[i]);
            tick();
            partial += terms[i];
            if (i < 3) begin
                ifm.in_valid = 1'b0;
                ifm.cout_in  = 1'b1;
                ifm.sum_in   = 4'hF;
                ifm.start    = (i == 1);
                tick();
                ifm.start = 1'b0;
                checks++; if (ifm.acc_out !== 7'(partial)) begin
                    failures++; $display("FAIL gap_hold got=%0d exp=%0d", ifm.acc_out, partial);
                end
            end
        end
        ifm.in_valid = 1'b0;
        checks++; if (ifm.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%0b exp=1", ifm.out_valid); end
        checks++; if (ifm.acc_out !== 7'd30) begin failures++; $display("FAIL gap_acc got=%0d exp=30", ifm.acc_out); end
        $display("test_gaps done acc=%0d", ifm.acc_out);
    endtask

    task automatic test_done_hold();
        ifm.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({ifm.out_valid, ifm.acc_out} !== {1'b1, 7'd30}) begin
                failures++; $display("FAIL hold got=%b/%0d exp=1/30", ifm.out_valid, ifm.acc_out);
            end
        end
        ifm.start = 1'b1;
        ifm.out_ready = 1'b1;
        tick();
        ifm.start = 1'b0;
        ifm.out_ready = 1'b0;
        checks++; if ({ifm.out_valid, ifm.busy} !== 2'b00) begin
            failures++; $display("FAIL start_dropped got=%b exp=00", {ifm.out_valid, ifm.busy});
        end
        drive_term(7);
        tick();
        ifm.in_valid = 1'b0;
        checks++; if ({ifm.busy, ifm.acc_out} !== {1'b0, 7'd30}) begin
            failures++; $display("FAIL idle_ignore got=%b/%0d exp=0/30", ifm.busy, ifm.acc_out);
        end
        pulse_start();
        checks++; if ({ifm.busy, ifm.acc_out} !== {1'b1, 7'd0}) begin
            failures++; $display("FAIL fresh_run got=%b/%0d exp=1/0", ifm.busy, ifm.acc_out);
        end
        $display("test_done_hold done");
    endtask

    task automatic test_async_reset();
        drive_term(9);
        tick();
        drive_term(11);
        tick();
        ifm.in_valid = 1'b0;
        checks++; if (ifm.acc_out !== 7'd20) begin failures++; $display("FAIL pre_reset_acc got=%0d exp=20", ifm.acc_out); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (ifm.acc_out !== 7'd0) begin failures++; $display("FAIL async_acc got=%0d exp=0", ifm.acc_out); end
        checks++; if ({ifm.in_ready, ifm.out_valid, ifm.busy, ifm.ovf} !== 4'b0000) begin
            failures++; $display("FAIL async_flags got=%b exp=0000", {ifm.in_ready, ifm.out_valid, ifm.busy, ifm.ovf});
        end
        #2;
        rst_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_term(5);
            tick();
        end
        ifm.in_valid = 1'b0;
        checks++; if ({ifm.out_valid, ifm.acc_out} !== {1'b1, 7'd20}) begin
            failures++; $display("FAIL post_reset_run got=%b/%0d exp=1/20", ifm.out_valid, ifm.acc_out);
        end
        ifm.out_ready = 1'b1;
        tick();
        ifm.out_ready = 1'b0;
        $display("test_async_reset done acc=%0d", ifm.acc_out);
    endtask

    task automatic test_single_term();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        checks++; if ({if1.in_ready, if1.out_valid} !== 2'b10) begin
            failures++; $display("FAIL single_accum got=%b exp=10", {if1.in_ready, if1.out_valid});
        end
        if1.in_valid = 1'b1;
        if1.cout_in  = 1'b1;
        if1.sum_in   = 4'd1;
        tick();
        if1.in_valid = 1'b0;
        checks++; if ({if1.out_valid, if1.in_ready, if1.acc_out} !== {2'b10, 7'd17}) begin
            failures++; $display("FAIL single_done got=%b/%0d exp=10/17", {if1.out_valid, if1.in_ready}, if1.acc_out);
        end
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;
        checks++; if (if1.busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", if1.busy); end
        $display("test_single_term done acc=%0d", if1.acc_out);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_gaps();
        test_done_hold();
        test_async_reset();
        test_single_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
